a2_bridge_responder: RTL and testbench
======================================

# a2_bridge_responder

Bridge-side responder for the FPGA-to-Apple II multiplexed bridge bus. It sits between the Apple II slot signals and the narrow 8-bit bridge port driven by the bus master. It answers select/read cycles with coherent snapshots of address, data, status and DIP switches. It accepts select/write cycles that update the GPIO control outputs or drive a data byte onto the Apple II data bus for one phi0 window.

## Interface
- `HOLD_CYCLES`, default 2: clk_logic cycles the Apple data bus stays driven after the phi0 falling edge.
- `ARM_TIMEOUT`, default 64: clk_logic cycles a latched output byte waits for phi0 high before it is discarded.
- `clk_logic` in 1: sole clock.
- `device_reset` in 1: asynchronous, active-high reset.
- `bridge_sel_i` in 3: register select from the master.
- `bridge_rd_n_i`, `bridge_wr_n_i` in 1 each: active-low read and write strobes.
- `bridge_d_i` in 8: write data from the master.
- `bridge_d_o` out 8: read data to the master.
- `bridge_d_oe_o` out 1: responder drives the bridge data lines.
- `bus_d_oe_n_i` in 1: master permission to drive the Apple data bus (low = allowed).
- `a2_addr_i` in 16, `a2_data_i` in 8, `a2_rw_n_i` in 1, `a2_m2sel_n_i` in 1, `a2_m2b0_i` in 1, `a2_phi0_i` in 1: raw slot inputs, asynchronous.
- `gpio_in_i` in 8: control inputs. Bit 0 is unused; `rw_n` replaces it.
- `dip_n_i` in 4: DIP switches, active low.
- `gpio_out_o` out 8: control outputs. Bit 2 is the slot IRQ_n.
- `a2_data_o` out 8, `a2_data_oe_o` out 1: Apple data bus drive.
- `protocol_err_o` out 1: sticky; set when `rd_n` and `wr_n` are low in the same cycle.

## Operation
- **Read map.** `bridge_d_o` is a combinational mux on `bridge_sel_i` over registered sources only:
  - sel 0: `{gpio_in_s[7:1], rw_n_snap}`
  - sel 1: `data_s`
  - sel 2: `addr_snap[7:0]`
  - sel 3: `addr_snap[15:8]`
  - sel 4: `{6'h3F, m2sel_n_snap, m2b0_snap}`
  - sel 5: `{4'hF, dip_n_s}`
  - sel 6/7: 8'hFF
- **Input synchronisation.** All slot, GPIO and DIP inputs pass through 2-flop synchronisers (suffix `_s`).
- **Snapshot.** On the first cycle with sel==2 and rd_n low (rising edge of that condition), latch `addr_snap`, `rw_n_snap`, `m2sel_n_snap` and `m2b0_snap` from the `_s` values. These hold until the next such edge, so the sel 3/0/4 reads that follow are coherent.
- **Read drive.** `bridge_d_oe_o` = !rd_n & wr_n.
- **Write capture and commit.**
  - While wr_n is low, capture `bridge_d_i` each cycle.
  - Commit on the first cycle wr_n is high after being low, using the last captured value and the sel registered at capture.
  - sel 0 commit: `gpio_out_o` <= data.
  - sel 1 commit: `out_byte` <= data and the drive FSM goes to ARMED.
  - Other sel values: no effect.
- **Protocol error.** When rd_n and wr_n are both low: no capture, no read drive, `protocol_err_o` <= 1. It clears only on reset.
- **Drive FSM** (phi0 edges from the synchronised `a2_phi0_s`):
  - IDLE: waiting for a sel 1 commit.
  - ARMED: a phi0 rising edge goes to DRIVE. A timeout counter reaching ARM_TIMEOUT goes to IDLE.
  - DRIVE: a phi0 falling edge goes to HOLD.
  - HOLD: stays HOLD_CYCLES cycles, then goes to IDLE.
  - A new sel 1 commit in any state reloads `out_byte` and enters ARMED.
- **Drive outputs.** `a2_data_o` = `out_byte`. `a2_data_oe_o` = (state DRIVE or HOLD) & !bus_d_oe_n_i.

## Timing
- **Reset values:**
  - `gpio_out_o`=8'hFF, `a2_data_o`=0, `a2_data_oe_o`=0, `protocol_err_o`=0, `bridge_d_oe_o`=0.
  - All snapshots 0.
  - FSM IDLE.
- **Read path:** the master changes sel at edge k and samples at edge k+1. The mux is therefore a same-cycle path.
- **Slot input latency:** a slot input change is visible in `_s` two edges later and in the snapshot three edges later.
- **Write commit:** `gpio_out_o` updates at the edge after wr_n returns high. A wr_n-low pulse of 1 cycle is sufficient.
- **Simultaneous events:**
  - Commit in the same cycle as a phi0 rising edge: commit wins, the FSM goes to ARMED, and drive starts at the next phi0 rise.
  - Snapshot edge in the same cycle as an input change: takes the `_s` value of that cycle.
- **Timeout counter:** 7-bit, saturating, and clears on entry to ARMED.
- **Reset mid-drive:** `a2_data_oe_o` drops asynchronously.

## Structure
- Package `a2_bridge_pkg` holds:
  - `SEL_CTRL`=0, `SEL_DATA`=1, `SEL_ADDR_LO`=2, `SEL_ADDR_HI`=3, `SEL_MEM2`=4, `SEL_DIP`=5
  - drive FSM enum `drive_state_t`
- Sub-module `a2_bridge_sync` (parameterised width, 2-flop synchroniser plus optional rise/fall edge outputs) is used for the slot inputs and phi0.

## Test plan
- **Reset:** assert `device_reset` -> `gpio_out_o`=8'hFF, `a2_data_oe_o`=0; sel 5 read with `dip_n_i`=4'b0111 returns 8'hF7.
- **Address snapshot:** `a2_addr_i`=16'hC0E9, rw_n=1, then sel 2/3/0 reads -> 8'hE9, 8'hC0, bit0=1. Changing the address to 16'h1234 after the sel 2 edge does not alter the sel 3 read.
- **GPIO write:** sel 0 with data 8'hFB, wr_n low for 1 cycle -> `gpio_out_o`=8'hFB at the edge after wr_n rises.
- **Data drive:** sel 1 write of 8'hA5, then phi0 high for 24 cycles -> `a2_data_oe_o` high from phi0_s rise until 2 cycles after phi0_s fall, `a2_data_o`=8'hA5. The same sequence with `bus_d_oe_n_i`=1 -> oe stays 0.
- **Arm timeout:** sel 1 write with phi0 held low for 70 cycles -> FSM returns to IDLE and no drive occurs at the later phi0 rise.
- **Protocol error:** rd_n and wr_n low together -> `protocol_err_o`=1, `gpio_out_o` unchanged, `bridge_d_oe_o`=0.

Source files
------------

// File: rtl/a2_bridge_pkg.sv
// Shared register-select codes and drive FSM encoding for the Apple II bridge responder.
package a2_bridge_pkg;

   localparam logic [2:0] SEL_CTRL    = 3'd0;
   localparam logic [2:0] SEL_DATA    = 3'd1;
   localparam logic [2:0] SEL_ADDR_LO = 3'd2;
   localparam logic [2:0] SEL_ADDR_HI = 3'd3;
   localparam logic [2:0] SEL_MEM2    = 3'd4;
   localparam logic [2:0] SEL_DIP     = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_DRIVE = 2'd2,
      ST_HOLD  = 2'd3
   } drive_state_t;

endpackage

// File: rtl/a2_bridge_sync.sv
// Two-flop synchroniser for a bus of asynchronous inputs, with optional
// rise/fall pulses derived from bit 0 of the synchronised bus.
module a2_bridge_sync #(
   parameter int WIDTH   = 1,
   parameter bit EDGE_EN = 1'b0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q,
   output logic             o_rise,
   output logic             o_fall
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

   generate
      if (EDGE_EN) begin : g_edge
         logic r_prev;
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) r_prev <= 1'b0;
            else       r_prev <= r_sync[0];
         end
         assign o_rise = r_sync[0] & ~r_prev;
         assign o_fall = ~r_sync[0] & r_prev;
      end else begin : g_no_edge
         assign o_rise = 1'b0;
         assign o_fall = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/a2_bridge_responder.sv
// Bridge-side responder: snapshot reads of the Apple II slot, GPIO writes and
// a phi0-timed drive of one byte onto the Apple data bus.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no byte pending for the Apple bus
// ST_ARMED | byte latched, waiting for phi0 rise (times out to IDLE)
// ST_DRIVE | driving the Apple data bus while phi0 is high
// ST_HOLD  | keep driving HOLD_CYCLES cycles after phi0 falls
module a2_bridge_responder
   import a2_bridge_pkg::*;
#(
   parameter int HOLD_CYCLES = 2,
   parameter int ARM_TIMEOUT = 64
) (
   input  logic        clk_logic,
   input  logic        device_reset,
   input  logic [2:0]  bridge_sel_i,
   input  logic        bridge_rd_n_i,
   input  logic        bridge_wr_n_i,
   input  logic [7:0]  bridge_d_i,
   output logic [7:0]  bridge_d_o,
   output logic        bridge_d_oe_o,
   input  logic        bus_d_oe_n_i,
   input  logic [15:0] a2_addr_i,
   input  logic [7:0]  a2_data_i,
   input  logic        a2_rw_n_i,
   input  logic        a2_m2sel_n_i,
   input  logic        a2_m2b0_i,
   input  logic        a2_phi0_i,
   input  logic [7:0]  gpio_in_i,
   input  logic [3:0]  dip_n_i,
   output logic [7:0]  gpio_out_o,
   output logic [7:0]  a2_data_o,
   output logic        a2_data_oe_o,
   output logic        protocol_err_o
);

   localparam int SYNC_W = 39;

   logic [SYNC_W-1:0] w_sync_d, w_sync_q;
   logic [7:1]  w_gpio_in_s;
   logic [3:0]  w_dip_n_s;
   logic [15:0] w_addr_s;
   logic [7:0]  w_data_s;
   logic        w_rw_n_s, w_m2sel_n_s, w_m2b0_s, w_phi0_s;
   logic        w_phi0_rise, w_phi0_fall;
   logic [1:0]  w_unused;

   // phi0 sits at bit 0 so the synchroniser's edge detector watches it
   assign w_sync_d = {gpio_in_i[7:1], dip_n_i, a2_addr_i, a2_data_i,
                      a2_rw_n_i, a2_m2sel_n_i, a2_m2b0_i, a2_phi0_i};
   assign {w_gpio_in_s, w_dip_n_s, w_addr_s, w_data_s,
           w_rw_n_s, w_m2sel_n_s, w_m2b0_s, w_phi0_s} = w_sync_q;
   assign w_unused = {gpio_in_i[0], w_phi0_s};

   a2_bridge_sync #(.WIDTH(SYNC_W), .EDGE_EN(1'b1)) u_sync (
      .i_clk  (clk_logic),
      .i_rst  (device_reset),
      .i_d    (w_sync_d),
      .o_q    (w_sync_q),
      .o_rise (w_phi0_rise),
      .o_fall (w_phi0_fall)
   );

   logic        w_rd, w_wr, w_snap_cond, w_commit, w_arm;
   logic        r_snap_cond_q, r_wr_pend, r_perr;
   logic [2:0]  r_wsel;
   logic [7:0]  r_wdata, r_gpio_out, r_out_byte;
   logic [15:0] r_addr_snap;
   logic        r_rw_n_snap, r_m2sel_n_snap, r_m2b0_snap;
   logic [6:0]  r_to_cnt;
   logic [7:0]  r_hold_cnt;
   drive_state_t r_state;

   assign w_rd        = ~bridge_rd_n_i;
   assign w_wr        = ~bridge_wr_n_i;
   assign w_snap_cond = w_rd && (bridge_sel_i == SEL_ADDR_LO);
   assign w_commit    = r_wr_pend & bridge_wr_n_i;
   assign w_arm       = w_commit && (r_wsel == SEL_DATA);

   always_ff @(posedge clk_logic or posedge device_reset) begin
      if (device_reset) begin
         r_snap_cond_q  <= 1'b0;
         r_addr_snap    <= '0;
         r_rw_n_snap    <= 1'b0;
         r_m2sel_n_snap <= 1'b0;
         r_m2b0_snap    <= 1'b0;
      end else begin
         r_snap_cond_q <= w_snap_cond;
         if (w_snap_cond && !r_snap_cond_q) begin
            r_addr_snap    <= w_addr_s;
            r_rw_n_snap    <= w_rw_n_s;
            r_m2sel_n_snap <= w_m2sel_n_s;
            r_m2b0_snap    <= w_m2b0_s;
         end
      end
   end

   // A cycle with both strobes low is never captured, but does not cancel a pending commit
   always_ff @(posedge clk_logic or posedge device_reset) begin
      if (device_reset) begin
         r_wr_pend  <= 1'b0;
         r_wsel     <= '0;
         r_wdata    <= '0;
         r_gpio_out <= 8'hFF;
         r_perr     <= 1'b0;
      end else begin
         if (w_wr && !w_rd) begin
            r_wr_pend <= 1'b1;
            r_wsel    <= bridge_sel_i;
            r_wdata   <= bridge_d_i;
         end else if (bridge_wr_n_i) begin
            r_wr_pend <= 1'b0;
         end
         if (w_commit && (r_wsel == SEL_CTRL)) r_gpio_out <= r_wdata;
         if (w_rd && w_wr) r_perr <= 1'b1;
      end
   end

   always_ff @(posedge clk_logic or posedge device_reset) begin
      if (device_reset) begin
         r_state    <= ST_IDLE;
         r_out_byte <= '0;
         r_to_cnt   <= '0;
         r_hold_cnt <= '0;
      end else if (w_arm) begin
         r_state    <= ST_ARMED;
         r_out_byte <= r_wdata;
         r_to_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: r_state <= ST_IDLE;
            ST_ARMED: begin
               if (w_phi0_rise)                         r_state  <= ST_DRIVE;
               else if (r_to_cnt == 7'(ARM_TIMEOUT))    r_state  <= ST_IDLE;
               else if (r_to_cnt != 7'h7F)              r_to_cnt <= r_to_cnt + 7'd1;
            end
            ST_DRIVE: begin
               if (w_phi0_fall) begin
                  r_state    <= ST_HOLD;
                  r_hold_cnt <= 8'(HOLD_CYCLES - 1);
               end
            end
            ST_HOLD: begin
               if (r_hold_cnt == 8'd0) r_state    <= ST_IDLE;
               else                    r_hold_cnt <= r_hold_cnt - 8'd1;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      bridge_d_o = 8'hFF;
      case (bridge_sel_i)
         SEL_CTRL:    bridge_d_o = {w_gpio_in_s, r_rw_n_snap};
         SEL_DATA:    bridge_d_o = w_data_s;
         SEL_ADDR_LO: bridge_d_o = r_addr_snap[7:0];
         SEL_ADDR_HI: bridge_d_o = r_addr_snap[15:8];
         SEL_MEM2:    bridge_d_o = {6'h3F, r_m2sel_n_snap, r_m2b0_snap};
         SEL_DIP:     bridge_d_o = {4'hF, w_dip_n_s};
         default:     bridge_d_o = 8'hFF;
      endcase
   end

   assign bridge_d_oe_o  = w_rd & ~w_wr;
   assign gpio_out_o     = r_gpio_out;
   assign protocol_err_o = r_perr;
   assign a2_data_o      = r_out_byte;
   assign a2_data_oe_o   = ((r_state == ST_DRIVE) || (r_state == ST_HOLD)) && !bus_d_oe_n_i;

endmodule

// File: tb/tb_a2_bridge_responder.sv
// Randomised bench for a2_bridge_responder against a behavioural model of the
// register map, snapshot coherence, GPIO writes and phi0-timed bus drive.
module tb_a2_bridge_responder;

   localparam int HOLD   = 2;
   localparam int ARM_TO = 64;

   logic        clk_logic = 1'b0;
   logic        device_reset;
   logic [2:0]  bridge_sel_i;
   logic        bridge_rd_n_i, bridge_wr_n_i;
   logic [7:0]  bridge_d_i, bridge_d_o;
   logic        bridge_d_oe_o, bus_d_oe_n_i;
   logic [15:0] a2_addr_i;
   logic [7:0]  a2_data_i;
   logic        a2_rw_n_i, a2_m2sel_n_i, a2_m2b0_i, a2_phi0_i;
   logic [7:0]  gpio_in_i;
   logic [3:0]  dip_n_i;
   logic [7:0]  gpio_out_o, a2_data_o;
   logic        a2_data_oe_o, protocol_err_o;

   int n_total = 0;
   int n_bad   = 0;

   // model state
   logic [15:0] m_addr_snap;
   logic        m_rw_snap, m_m2sel_snap, m_m2b0_snap;
   logic [7:0]  m_gpio_out;

   a2_bridge_responder #(.HOLD_CYCLES(HOLD), .ARM_TIMEOUT(ARM_TO)) dut (
      .clk_logic      (clk_logic),
      .device_reset   (device_reset),
      .bridge_sel_i   (bridge_sel_i),
      .bridge_rd_n_i  (bridge_rd_n_i),
      .bridge_wr_n_i  (bridge_wr_n_i),
      .bridge_d_i     (bridge_d_i),
      .bridge_d_o     (bridge_d_o),
      .bridge_d_oe_o  (bridge_d_oe_o),
      .bus_d_oe_n_i   (bus_d_oe_n_i),
      .a2_addr_i      (a2_addr_i),
      .a2_data_i      (a2_data_i),
      .a2_rw_n_i      (a2_rw_n_i),
      .a2_m2sel_n_i   (a2_m2sel_n_i),
      .a2_m2b0_i      (a2_m2b0_i),
      .a2_phi0_i      (a2_phi0_i),
      .gpio_in_i      (gpio_in_i),
      .dip_n_i        (dip_n_i),
      .gpio_out_o     (gpio_out_o),
      .a2_data_o      (a2_data_o),
      .a2_data_oe_o   (a2_data_oe_o),
      .protocol_err_o (protocol_err_o)
   );

   always #5 clk_logic = ~clk_logic;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_logic);
   endtask

   function automatic logic [7:0] exp_read(input logic [2:0] sel);
      case (sel)
         3'd0:    return {gpio_in_i[7:1], m_rw_snap};
         3'd1:    return a2_data_i;
         3'd2:    return m_addr_snap[7:0];
         3'd3:    return m_addr_snap[15:8];
         3'd4:    return {6'h3F, m_m2sel_snap, m_m2b0_snap};
         3'd5:    return {4'hF, dip_n_i};
         default: return 8'hFF;
      endcase
   endfunction

   // Master read: sel and rd_n set at one edge, data sampled after the next.
   task automatic bus_read(input logic [2:0] sel, output logic [7:0] d);
      bridge_sel_i  = sel;
      bridge_rd_n_i = 1'b0;
      cyc(1);
      d = bridge_d_o;
      check("rd_oe", bridge_d_oe_o, 1'b1);
      if (sel == 3'd2) begin
         m_addr_snap  = a2_addr_i;
         m_rw_snap    = a2_rw_n_i;
         m_m2sel_snap = a2_m2sel_n_i;
         m_m2b0_snap  = a2_m2b0_i;
      end
      bridge_rd_n_i = 1'b1;
   endtask

   task automatic read_chk(input string tag, input logic [2:0] sel);
      logic [7:0] d;
      bus_read(sel, d);
      check(tag, d, exp_read(sel));
   endtask

   // Single-cycle write strobe; sel/data are scrambled afterwards so the
   // commit must rely on what was captured.
   task automatic bus_write(input logic [2:0] sel, input logic [7:0] d);
      bridge_sel_i  = sel;
      bridge_d_i    = d;
      bridge_wr_n_i = 1'b0;
      cyc(1);
      bridge_wr_n_i = 1'b1;
      bridge_sel_i  = 3'($urandom);
      bridge_d_i    = 8'($urandom);
      check("gpio_pre", gpio_out_o, m_gpio_out);
      cyc(1);
      if (sel == 3'd0) m_gpio_out = d;
      check("gpio_post", gpio_out_o, m_gpio_out);
   endtask

   // Arm a byte, wait pre_low cycles with phi0 low, then hold phi0 high hi_len cycles.
   task automatic drive_run(input string tag, input logic [7:0] b, input int pre_low,
                            input int hi_len, input logic allow);
      int first, cnt, bad_data;
      logic exp_drive;
      exp_drive    = allow && (pre_low + 2 <= ARM_TO);
      bus_d_oe_n_i = ~allow;
      bus_write(3'd1, b);
      cyc(pre_low);
      a2_phi0_i = 1'b1;
      first = -1; cnt = 0; bad_data = 0;
      for (int i = 1; i <= hi_len + 16; i++) begin
         cyc(1);
         if (a2_data_oe_o) begin
            if (first < 0) first = i;
            cnt++;
            if (a2_data_o !== b) bad_data++;
         end
         if (i == hi_len) a2_phi0_i = 1'b0;
      end
      check({tag, "_cnt"},   cnt,   exp_drive ? hi_len + HOLD : 0);
      check({tag, "_first"}, first, exp_drive ? 3 : -1);
      check({tag, "_data"},  bad_data, 0);
      check({tag, "_byte"},  a2_data_o, b);
      bus_d_oe_n_i = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      device_reset  = 1'b1;
      bridge_sel_i  = 3'd0;
      bridge_rd_n_i = 1'b1;
      bridge_wr_n_i = 1'b1;
      bridge_d_i    = 8'h00;
      bus_d_oe_n_i  = 1'b0;
      a2_addr_i     = 16'h0000;
      a2_data_i     = 8'h00;
      a2_rw_n_i     = 1'b0;
      a2_m2sel_n_i  = 1'b0;
      a2_m2b0_i     = 1'b0;
      a2_phi0_i     = 1'b0;
      gpio_in_i     = 8'h00;
      dip_n_i       = 4'b0111;
      m_gpio_out    = 8'hFF;
      m_addr_snap   = 16'h0000;
      m_rw_snap     = 1'b0;
      m_m2sel_snap  = 1'b0;
      m_m2b0_snap   = 1'b0;
      cyc(3);
      check("rst_gpio",  gpio_out_o, 8'hFF);
      check("rst_oe",    a2_data_oe_o, 1'b0);
      check("rst_data",  a2_data_o, 8'h00);
      check("rst_perr",  protocol_err_o, 1'b0);
      check("rst_rdoe",  bridge_d_oe_o, 1'b0);
      device_reset = 1'b0;
      cyc(3);

      bus_read(3'd5, d);
      check("rst_dip_f7", d, 8'hF7);
      read_chk("rst_addr_hi", 3'd3);
      read_chk("rst_mem2", 3'd4);
      read_chk("sel6", 3'd6);
      read_chk("sel7", 3'd7);

      a2_addr_i = 16'hC0E9;
      a2_rw_n_i = 1'b1;
      cyc(3);
      bus_read(3'd2, d);
      check("snap_lo_e9", d, 8'hE9);
      a2_addr_i = 16'h1234;
      a2_rw_n_i = 1'b0;
      cyc(3);
      bus_read(3'd3, d);
      check("snap_hi_c0", d, 8'hC0);
      bus_read(3'd0, d);
      check("snap_rw_1", d[0], 1'b1);

      for (int k = 0; k < 8; k++) begin
         a2_addr_i    = 16'($urandom);
         a2_rw_n_i    = 1'($urandom);
         a2_m2sel_n_i = 1'($urandom);
         a2_m2b0_i    = 1'($urandom);
         a2_data_i    = 8'($urandom);
         gpio_in_i    = 8'($urandom);
         dip_n_i      = 4'($urandom);
         cyc(3);
         read_chk("r_lo", 3'd2);
         a2_addr_i    = 16'($urandom);
         a2_rw_n_i    = 1'($urandom);
         a2_m2sel_n_i = 1'($urandom);
         cyc(3);
         read_chk("r_hi",   3'd3);
         read_chk("r_ctl",  3'd0);
         read_chk("r_mem2", 3'd4);
         read_chk("r_data", 3'd1);
         read_chk("r_dip",  3'd5);
      end

      bus_write(3'd0, 8'hFB);
      check("gpio_fb", gpio_out_o, 8'hFB);
      for (int k = 0; k < 6; k++) bus_write(3'($urandom_range(0, 5)), 8'($urandom));

      drive_run("drv_a5",  8'hA5, 0, 24, 1'b1);
      drive_run("drv_blk", 8'hA5, 0, 24, 1'b0);
      for (int k = 0; k < 3; k++)
         drive_run("drv_rnd", 8'($urandom), $urandom_range(0, 30), $urandom_range(8, 30), 1'b1);
      drive_run("drv_late", 8'h5C, 40, 10, 1'b1);
      drive_run("arm_to",   8'h3C, 70, 20, 1'b1);

      bus_write(3'd0, 8'h5A);
      check("perr_pre", protocol_err_o, 1'b0);
      bridge_sel_i  = 3'd0;
      bridge_d_i    = 8'h00;
      bridge_rd_n_i = 1'b0;
      bridge_wr_n_i = 1'b0;
      #1;
      check("perr_rdoe", bridge_d_oe_o, 1'b0);
      cyc(1);
      check("perr_set", protocol_err_o, 1'b1);
      bridge_rd_n_i = 1'b1;
      bridge_wr_n_i = 1'b1;
      cyc(3);
      check("perr_gpio",   gpio_out_o, m_gpio_out);
      check("perr_sticky", protocol_err_o, 1'b1);

      bus_write(3'd1, 8'h77);
      a2_phi0_i = 1'b1;
      cyc(5);
      check("mid_oe_pre", a2_data_oe_o, 1'b1);
      #2;
      device_reset = 1'b1;
      #1;
      check("mid_oe_async", a2_data_oe_o, 1'b0);
      check("mid_gpio",     gpio_out_o, 8'hFF);
      check("mid_perr",     protocol_err_o, 1'b0);
      cyc(2);
      device_reset = 1'b0;
      a2_phi0_i    = 1'b0;
      m_gpio_out   = 8'hFF;
      m_addr_snap  = 16'h0000;
      m_rw_snap    = 1'b0;
      m_m2sel_snap = 1'b0;
      m_m2b0_snap  = 1'b0;
      cyc(3);
      read_chk("mid_snap_hi", 3'd3);
      read_chk("mid_mem2",    3'd4);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
